// File: rtl/dp_pkg.sv
// Shared definitions for the 16-bit pipelined datapath.
// Widths, opcodes and the fetch FSM state encoding.
package dp_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 16;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_SW  = 4'b1010;
    localparam logic [3:0] OP_BNE = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ifid_reg.sv
// Generic stage register: load captures, flush inserts a bubble
// (payload pc kept), otherwise holds.
module ifid_reg #(
    parameter int          IW       = 16,
    parameter int          AW       = 16,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          flush,
    input  logic [IW-1:0] instr_in,
    input  logic [AW-1:0] pc_next_in,
    output logic [IW-1:0] instr,
    output logic [AW-1:0] pc_next,
    output logic          valid
);

    logic [IW-1:0] instr_q, instr_d;
    logic [AW-1:0] pc_next_q, pc_next_d;
    logic          valid_q, valid_d;

    always_comb begin
        instr_d   = instr_q;
        pc_next_d = pc_next_q;
        valid_d   = valid_q;
        if (flush) begin
            instr_d = IW'(NOP_WORD);
            valid_d = 1'b0;
        end else if (load) begin
            instr_d   = instr_in;
            pc_next_d = pc_next_in;
            valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q   <= IW'(NOP_WORD);
            pc_next_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pc_next_q <= pc_next_d;
            valid_q   <= valid_d;
        end
    end

    assign instr   = instr_q;
    assign pc_next = pc_next_q;
    assign valid   = valid_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// IF stage: PC register, fetch FSM (IDLE/FETCH/HALT) and IF/ID capture.
// Branch redirect beats stall; the end of memory parks the stage in HALT.
module instr_fetch_stage #(
    parameter int          MEM_DEPTH = 64,
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] pc_addr,
    input  logic [15:0] instr_in,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_next,
    output logic        ifid_valid,
    output logic        halted,
    output logic [15:0] fetch_count
);

    import dp_pkg::*;

    localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(MEM_DEPTH);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
    logic [15:0]       cnt_q, cnt_d;
    logic              halted_q, halted_d;
    logic              load, flush;

    always_comb begin
        pc_inc  = pc_q + 16'd1;
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (branch_taken) begin
                    pc_d  = branch_target;
                    flush = 1'b1;
                    if (branch_target >= DEPTH)
                        state_d = ST_HALT;
                end else if (!stall) begin
                    load = 1'b1;
                    pc_d = pc_inc;
                    if (cnt_q != 16'hFFFF)
                        cnt_d = cnt_q + 16'd1;
                    if (pc_inc == DEPTH)
                        state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                flush = 1'b1;
                if (branch_taken && branch_target < DEPTH) begin
                    pc_d    = branch_target;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
        end
    end

    ifid_reg #(
        .IW       (INSTR_W),
        .AW       (ADDR_W),
        .NOP_WORD (NOP_INSTR)
    ) u_ifid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .flush      (flush),
        .instr_in   (instr_in),
        .pc_next_in (pc_inc),
        .instr      (ifid_instr),
        .pc_next    (ifid_pc_next),
        .valid      (ifid_valid)
    );

    assign pc_addr     = pc_q;
    assign halted      = halted_q;
    assign fetch_count = cnt_q;

endmodule
